// File: rtl/encoded_pkg.sv
// Shared definitions for the symbol encoder and the decoder: encoder state
// encoding, line symbol codes and the transition table used to recover bits.
package encoded_pkg;

    // Encoder state as tracked by the decoder (also its debug-visible encoding).
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Line symbol codes. Each symbol names the state the encoder moved into.
    localparam logic [1:0] SYM_S0 = 2'b01;
    localparam logic [1:0] SYM_S1 = 2'b10;
    localparam logic [1:0] SYM_S2 = 2'b11;
    localparam logic [1:0] SYM_S3 = 2'b00;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    // Result of classifying one state transition.
    typedef struct packed {
        logic legal;    // transition exists in the encoder
        logic emit;     // transition carries a data bit
        logic bit_val;  // the data bit carried (valid when emit=1)
    } trans_t;

    // Map a received symbol to the encoder state it announces.
    function automatic state_t sym_to_state(input logic [1:0] sym);
        state_t st;
        case (sym)
            SYM_S0:  st = S0;
            SYM_S1:  st = S1;
            SYM_S2:  st = S2;
            default: st = S3;
        endcase
        return st;
    endfunction

    // Classify cur->nxt. Moves into S0 are never legal here: a symbol naming
    // S0 is an encoder-reset marker and is handled before this lookup.
    function automatic trans_t check_trans(input state_t cur, input state_t nxt);
        trans_t t;
        t = '{legal: 1'b0, emit: 1'b0, bit_val: 1'b0};
        case ({cur, nxt})
            {S0, S1}: t = '{legal: 1'b1, emit: 1'b0, bit_val: 1'b0};
            {S1, S2}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b1};
            {S1, S1}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b0};
            {S2, S3}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b1};
            {S2, S1}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b0};
            {S3, S2}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b1};
            {S3, S3}: t = '{legal: 1'b1, emit: 1'b1, bit_val: 1'b0};
            default:  t = '{legal: 1'b0, emit: 1'b0, bit_val: 1'b0};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects recovered bits into a byte, LSB first. A 3-bit counter selects the
// bit position written; byte_valid pulses with the 8th bit of each byte.
module byte_assembler
    import encoded_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    input  logic              i_clr,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_byte_valid
);

    logic [CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_byte;
    logic              r_byte_valid;

    // Write each bit into its slot; counter clear restarts the byte without
    // disturbing bits already held in the byte register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_bit_valid) begin
                r_byte[r_cnt] <= i_bit;
                r_cnt         <= r_cnt + 1'b1;
                r_byte_valid  <= (r_cnt == CNT_W'(BYTE_W - 1));
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;

endmodule

// File: rtl/decoded.sv
// Symbol stream decoder: tracks the encoder state from received symbols,
// recovers data bits from legal transitions, flags illegal ones and hands
// bits to the byte assembler.
//
// Handshake: sym_in is consumed on every rising edge where sym_valid=1; there
// is no back-pressure. bit_valid, byte_valid and err are single-cycle pulses
// one cycle after the consuming edge and qualify bit_out / byte_out.
module decoded
    import encoded_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sym_in,
    input  logic        sym_valid,
    input  logic        err_clr,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        synced,
    output logic [1:0]  estados,
    output logic        err,
    output logic        err_sticky
);

    state_t r_state;
    logic   r_synced;
    logic   r_bit_out;
    logic   r_bit_valid;
    logic   r_err;
    logic   r_err_sticky;

    state_t w_sym_state;
    trans_t w_trans;
    logic   w_active;
    logic   w_marker;
    logic   w_illegal;
    logic   w_bit_fire;
    logic   w_cnt_clr;

    assign w_sym_state = sym_to_state(sym_in);
    assign w_trans     = check_trans(r_state, w_sym_state);

    // Only a valid symbol while synced is checked against the transition table.
    assign w_active   = sym_valid & r_synced;
    assign w_marker   = w_active & (sym_in == SYM_S0);
    assign w_illegal  = w_active & ~w_marker & ~w_trans.legal;
    assign w_bit_fire = w_active & ~w_marker & w_trans.legal & w_trans.emit;
    assign w_cnt_clr  = w_marker | w_illegal;

    // Tracking FSM: unsynced -> load state from symbol; synced -> follow legal
    // transitions, re-anchor on markers, drop sync on illegal symbols.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S0;
            r_synced     <= 1'b0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_bit_valid <= w_bit_fire;
            r_err       <= w_illegal;
            if (w_bit_fire) begin
                r_bit_out <= w_trans.bit_val;
            end
            // Setting from a new error takes priority over a clear request.
            if (w_illegal) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
            if (sym_valid) begin
                if (!r_synced) begin
                    r_state  <= w_sym_state;
                    r_synced <= 1'b1;
                end else if (w_marker) begin
                    r_state <= S0;
                end else if (w_illegal) begin
                    r_synced <= 1'b0;
                end else begin
                    r_state <= w_sym_state;
                end
            end
        end
    end

    byte_assembler u_byte_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_bit_valid  (w_bit_fire),
        .i_bit        (w_trans.bit_val),
        .i_clr        (w_cnt_clr),
        .o_byte       (byte_out),
        .o_byte_valid (byte_valid)
    );

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign synced     = r_synced;
    assign estados    = r_state;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_decoded.sv
// Directed bench for the symbol decoder with hand-computed expectations.
module tb_decoded;

    logic       clk;
    logic       reset;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       err_clr;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       synced;
    logic [1:0] estados;
    logic       err;
    logic       err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    // Symbol/bit vectors that assemble to 0xA5 (LSB first).
    logic [1:0] vec_sym [8] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
    logic       vec_bit [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    decoded dut (
        .clk        (clk),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .err_clr    (err_clr),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .synced     (synced),
        .estados    (estados),
        .err        (err),
        .err_sticky (err_sticky)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        sym_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one symbol for one edge, then check the registered pulses.
    task automatic send_sym(input string tag, input logic [1:0] sym, input logic exp_bv,
                            input logic exp_bit, input logic exp_err, input logic exp_byv);
        @(negedge clk);
        sym_in    = sym;
        sym_valid = 1'b1;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        check({tag, ".bit_valid"}, bit_valid, exp_bv);
        if (exp_bv) check({tag, ".bit_out"}, bit_out, exp_bit);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".byte_valid"}, byte_valid, exp_byv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle.pulses", {bit_valid, byte_valid, err}, 3'b000);
        end
    endtask

    initial begin
        reset     = 1'b1;
        sym_in    = 2'b00;
        sym_valid = 1'b0;
        err_clr   = 1'b0;
        apply_reset();
        #1;
        check("rst.synced", synced, 1'b0);
        check("rst.estados", estados, 2'b00);
        check("rst.byte_out", byte_out, 8'h00);
        check("rst.bit_out", bit_out, 1'b0);
        check("rst.pulses", {bit_valid, byte_valid, err, err_sticky}, 4'b0000);

        // Basic decode: 01,10,11,00,00,11 -> -, -, 1, 1, 0, 1
        send_sym("a0", 2'b01, 0, 0, 0, 0);
        check("a0.synced", synced, 1'b1);
        check("a0.estados", estados, 2'b00);
        send_sym("a1", 2'b10, 0, 0, 0, 0);
        send_sym("a2", 2'b11, 1, 1, 0, 0);
        send_sym("a3", 2'b00, 1, 1, 0, 0);
        send_sym("a4", 2'b00, 1, 0, 0, 0);
        send_sym("a5", 2'b11, 1, 1, 0, 0);
        check("a.estados", estados, 2'b10);
        check("a.sticky", err_sticky, 1'b0);

        // Full byte 0xA5
        apply_reset();
        send_sym("b0", 2'b01, 0, 0, 0, 0);
        send_sym("b1", 2'b10, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) send_sym("b.vec", vec_sym[i], 1, vec_bit[i], 0, (i == 7));
        check("b.byte_out", byte_out, 8'hA5);

        // Illegal transition, resync, sticky clear
        apply_reset();
        send_sym("c0", 2'b10, 0, 0, 0, 0);
        check("c0.estados", estados, 2'b01);
        send_sym("c1", 2'b00, 0, 0, 1, 0);
        check("c1.sticky", err_sticky, 1'b1);
        check("c1.synced", synced, 1'b0);
        check("c1.estados", estados, 2'b01);
        send_sym("c2", 2'b11, 0, 0, 0, 0);
        check("c2.synced", synced, 1'b1);
        check("c2.estados", estados, 2'b10);
        check("c2.sticky", err_sticky, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("c3.sticky", err_sticky, 1'b0);

        // Encoder-reset marker mid-byte restarts the bit counter
        apply_reset();
        send_sym("d0", 2'b01, 0, 0, 0, 0);
        send_sym("d1", 2'b10, 0, 0, 0, 0);
        send_sym("d2", 2'b11, 1, 1, 0, 0);
        send_sym("d3", 2'b10, 1, 0, 0, 0);
        send_sym("d4", 2'b11, 1, 1, 0, 0);
        send_sym("d5", 2'b01, 0, 0, 0, 0);
        check("d5.estados", estados, 2'b00);
        check("d5.synced", synced, 1'b1);
        check("d5.byte_hold", byte_out, 8'h05);
        send_sym("d6", 2'b10, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) send_sym("d.vec", vec_sym[i], 1, vec_bit[i], 0, (i == 7));
        check("d.byte_out", byte_out, 8'hA5);
        check("d.sticky", err_sticky, 1'b0);

        // Idle gaps between symbols, then reset mid-byte
        apply_reset();
        send_sym("e0", 2'b01, 0, 0, 0, 0); idle(2);
        send_sym("e1", 2'b10, 0, 0, 0, 0); idle(2);
        send_sym("e2", 2'b11, 1, 1, 0, 0); idle(2);
        send_sym("e3", 2'b00, 1, 1, 0, 0); idle(2);
        send_sym("e4", 2'b00, 1, 0, 0, 0); idle(2);
        send_sym("e5", 2'b11, 1, 1, 0, 0); idle(2);
        check("e.estados", estados, 2'b10);
        check("e.byte_part", byte_out, 8'h0B);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("e.rst_byte", byte_out, 8'h00);
        check("e.rst_bit", bit_out, 1'b0);
        check("e.rst_synced", synced, 1'b0);
        check("e.rst_estados", estados, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        send_sym("e6", 2'b11, 0, 0, 0, 0);
        check("e6.synced", synced, 1'b1);
        check("e6.estados", estados, 2'b10);

        // Clear request coinciding with an illegal symbol: set wins
        apply_reset();
        send_sym("f0", 2'b10, 0, 0, 0, 0);
        err_clr = 1'b1;
        send_sym("f1", 2'b00, 0, 0, 1, 0);
        err_clr = 1'b0;
        check("f1.sticky", err_sticky, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
